// File: rtl/urcpu_pkg.sv
// urcpu_pkg: shared CPU datapath constants (word width, register count, register address width)
package urcpu_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-bit tracking and source-hazard stall (pending[i] = reg i awaiting write-back)
module reg_scoreboard
  import urcpu_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int AW    = REG_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [AW-1:0]    raddr_a,
  input  logic             use_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             use_b,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_dst,
  output logic             stall,
  output logic [NREGS-1:0] pending
);
  logic [NREGS-1:0] pend, set_m, clr_m;
  logic hazard_a, hazard_b, accept;
  always_comb begin
    hazard_a = use_a & pend[raddr_a] & ~(we & (waddr == raddr_a));
    hazard_b = use_b & pend[raddr_b] & ~(we & (waddr == raddr_b));
    stall    = hazard_a | hazard_b;
    accept   = iss_valid & ~stall & (iss_dst != '0);
    set_m    = accept ? NREGS'(1) << iss_dst : '0;
    clr_m    = we ? NREGS'(1) << waddr : '0;
  end
  always_ff @(posedge clk)
    if (rst) pend <= '0;
    else     pend <= ((pend & ~clr_m) | set_m) & ~NREGS'(1);
  assign pending = pend;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with write-back bypass, r0 hardwired to 0, and issue scoreboard
module reg_file_sb
  import urcpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NREGS = NUM_REGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic             use_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             use_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_dst,
  output logic             stall,
  output logic [NREGS-1:0] pending
);
  logic [WIDTH-1:0] regs [NREGS];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we && waddr != '0) regs[waddr] <= wdata;
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : (we && waddr == raddr_a) ? wdata : regs[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : (we && waddr == raddr_b) ? wdata : regs[raddr_b];
  end
  reg_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .raddr_a(raddr_a), .use_a(use_a), .raddr_b(raddr_b), .use_b(use_b),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .stall(stall), .pending(pending)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb against a behavioural register/pending model
module tb_reg_file_sb;
  logic clk = 0, rst, we, use_a, use_b, iss_valid, stall;
  logic [2:0] waddr, raddr_a, raddr_b, iss_dst;
  logic [7:0] wdata, rdata_a, rdata_b, pending;
  typedef struct {
    logic [7:0] a, b, p;
    logic s;
    string tag;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [7:0] mreg [8];
  bit mpend [8];
  always #5 clk = ~clk;
  reg_file_sb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .use_a(use_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .use_b(use_b), .rdata_b(rdata_b),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .stall(stall), .pending(pending)
  );
  function automatic logic [7:0] mread(input logic [2:0] ra);
    if (ra == 0) return 8'h00;
    if (we && waddr == ra) return wdata;
    return mreg[ra];
  endfunction
  task automatic step(input bit r, w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input bit ua, input logic [2:0] rb, input bit ub,
                      input bit iv, input logic [2:0] id, input bit chk, input string tag);
    exp_t e;
    bit st;
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; use_a = ua;
    raddr_b = rb; use_b = ub; iss_valid = iv; iss_dst = id;
    st = (ua && mpend[ra] && !(w && wa == ra)) || (ub && mpend[rb] && !(w && wa == rb));
    e.a = mread(ra);
    e.b = mread(rb);
    e.s = st;
    for (int i = 0; i < 8; i++) e.p[i] = mpend[i];
    e.tag = tag;
    if (chk) q.push_back(e);
    if (r) begin
      for (int i = 0; i < 8; i++) begin mreg[i] = 0; mpend[i] = 0; end
    end else begin
      if (w && wa != 0) mreg[wa] = wd;
      if (w) mpend[wa] = 0;
      if (iv && !st && id != 0) mpend[id] = 1;
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 4;
      if (rdata_a !== e.a) begin errors++; $display("FAIL %s rdata_a got %h exp %h", e.tag, rdata_a, e.a); end
      if (rdata_b !== e.b) begin errors++; $display("FAIL %s rdata_b got %h exp %h", e.tag, rdata_b, e.b); end
      if (stall !== e.s) begin errors++; $display("FAIL %s stall got %b exp %b", e.tag, stall, e.s); end
      if (pending !== e.p) begin errors++; $display("FAIL %s pending got %b exp %b", e.tag, pending, e.p); end
    end
  initial begin
    rst = 1; we = 0; waddr = 0; wdata = 0; raddr_a = 0; use_a = 0; raddr_b = 0; use_b = 0;
    iss_valid = 0; iss_dst = 0;
    for (int i = 0; i < 8; i++) begin mreg[i] = 'x; mpend[i] = 0; end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "init_rst");
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, "after_rst");
    step(0, 1, 3, 8'hA5, 0, 0, 0, 0, 0, 0, 1, "wr3");
    step(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, "rd3_rd0");
    step(0, 1, 0, 8'hFF, 0, 0, 0, 0, 1, 0, 1, "wr0_iss0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "r0_not_pending");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, "iss5");
    step(0, 0, 0, 0, 5, 1, 0, 0, 1, 2, 1, "stall_iss2");
    step(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, "iss2_ignored");
    step(0, 1, 5, 8'h3C, 5, 1, 5, 1, 0, 0, 1, "wb5_bypass");
    step(0, 0, 0, 0, 5, 1, 0, 0, 1, 4, 1, "pend5_clear_iss4");
    step(0, 1, 4, 8'h77, 4, 0, 0, 0, 1, 4, 1, "wb4_iss4");
    step(0, 0, 0, 0, 4, 0, 4, 1, 0, 0, 1, "reg4_still_pend");
    step(0, 1, 4, 8'h11, 0, 0, 0, 0, 1, 6, 1, "wb4_iss6");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, "iss5b");
    step(0, 1, 2, 8'h22, 0, 0, 0, 0, 0, 0, 1, "plain_wr2");
    step(1, 1, 3, 8'h99, 6, 1, 5, 1, 1, 1, 1, "rst_mid");
    step(0, 0, 0, 0, 3, 1, 5, 1, 0, 0, 1, "post_rst_reads");
    step(0, 0, 0, 0, 6, 1, 2, 1, 0, 0, 1, "post_rst_reads2");
    step(0, 1, 6, 8'h5A, 6, 1, 0, 0, 0, 0, 1, "wb6_plain");
    step(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, "rd6");
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4, 3'($urandom), 8'($urandom),
           3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
           $urandom_range(0, 1) == 1, 3'($urandom), 1, "rand");
    @(posedge clk);
    #1;
    we = 0; iss_valid = 0; use_a = 0; use_b = 0;
    repeat (5) @(negedge clk);
    if (q.size() != 0) begin errors++; $display("FAIL drain queue left %0d exp 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 8, number of architectural registers (power of two, >=2).
REQ-003 SHALL have derived parameter AW = log2(NREGS), default 3, register address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port we  input  1  write-back enable.
REQ-007 SHALL have port waddr  input  AW  write-back destination register.
REQ-008 SHALL have port wdata  input  WIDTH  write-back data.
REQ-009 SHALL have port raddr_a  input  AW  read port A address.
REQ-010 SHALL have port use_a  input  1  read port A is a live source this cycle.
REQ-011 SHALL have port rdata_a  output  WIDTH  read port A data.
REQ-012 SHALL have port raddr_b  input  AW  read port B address.
REQ-013 SHALL have port use_b  input  1  read port B is a live source this cycle.
REQ-014 SHALL have port rdata_b  output  WIDTH  read port B data.
REQ-015 SHALL have port iss_valid  input  1  instruction issue request with a destination.
REQ-016 SHALL have port iss_dst  input  AW  destination of the issuing instruction.
REQ-017 SHALL have port stall  output  1  source hazard; issue is blocked this cycle.
REQ-018 SHALL have port pending  output  NREGS  scoreboard bit vector, bit i = register i awaiting write-back.

Function
REQ-019 SHALL hold NREGS registers of WIDTH bits; register 0 SHALL always read 0, ignore writes and never be pending.
REQ-020 SHALL write wdata into register waddr at the rising edge when we=1 and waddr!=0.
REQ-021 SHALL drive rdata_a and rdata_b combinationally (zero-cycle read latency).
REQ-022 SHALL bypass: when we=1 and waddr==raddr_x!=0, rdata_x SHALL equal wdata in the same cycle.
REQ-023 SHALL compute hazard_x = use_x & pending[raddr_x] & ~(we & waddr==raddr_x), for x in {a,b}.
REQ-024 SHALL drive stall = hazard_a | hazard_b, combinationally.
REQ-025 SHALL accept an issue only when iss_valid=1, stall=0 and iss_dst!=0; an accepted issue SHALL set pending[iss_dst] at the next edge.
REQ-026 SHALL clear pending[waddr] at the edge when we=1, unless an accepted issue targets the same register that cycle.
REQ-027 SHALL give an accepted issue priority when issue and write-back target the same register in the same cycle: the data is written and pending ends 1.
REQ-028 SHALL ignore an issue while stall=1: no scoreboard change.
REQ-029 SHALL treat a write-back to a non-pending register as a plain write; pending is unchanged.
REQ-030 SHALL allow issues to distinct registers on consecutive cycles with no limit other than NREGS-1 outstanding.

Reset
REQ-031 SHALL, while rst=1 at a rising edge, clear all registers to 0 and all pending bits to 0, overriding we and iss_valid.
REQ-032 SHALL drive, in the cycle after reset, rdata_a=rdata_b=0 (absent bypass), pending=0 and stall=0.
REQ-033 SHALL discard, on reset mid-operation, all outstanding pending bits; a later write-back to those registers SHALL act as a plain write.

Structure
REQ-034 SHALL take WIDTH, NREGS and AW defaults from shared package urcpu_pkg, alongside the CPU's other datapath constants.
REQ-035 SHALL isolate the pending-bit logic (REQ-023 to REQ-030) in sub-module reg_scoreboard; storage and bypass SHALL stay in reg_file_sb.

Verification
REQ-036 SHALL verify: rst=1 for one edge then we=1 waddr=3 wdata=8'hA5 -> next cycle raddr_a=3 gives rdata_a=8'hA5; raddr_b=0 gives 0.
REQ-037 SHALL verify: we=1 waddr=0 wdata=8'hFF -> rdata_a(raddr_a=0)=0; pending[0] stays 0 after iss_valid=1 iss_dst=0.
REQ-038 SHALL verify: iss_dst=5 accepted -> pending=8'b0010_0000; then raddr_a=5 use_a=1 -> stall=1; same cycle iss_valid=1 iss_dst=2 -> pending[2] stays 0.
REQ-039 SHALL verify: pending[5]=1, we=1 waddr=5 wdata=8'h3C, raddr_a=5 use_a=1 -> stall=0, rdata_a=8'h3C same cycle, pending[5]=0 next cycle.
REQ-040 SHALL verify: pending[4]=1, same cycle we=1 waddr=4 and accepted issue iss_dst=4 -> register 4 holds wdata, pending[4]=1 next cycle.
REQ-041 SHALL verify: pending=8'b0110_0000, rst=1 one edge -> pending=0, all reads 0, stall=0 with use_a=use_b=1.
